rs_multi_cdb: RTL
=================

# rs_multi_cdb

Parametrised reservation station for the out-of-order RISC-V core, placed between the ROB/dispatch stage and one ALU. It holds up to RS_DEPTH renamed instructions and captures operand values from NUM_CDB common-data-bus channels, including operands broadcast in the same cycle they are dispatched. It issues the oldest ready instruction through a registered valid/ready stage and flushes on ROB exception.

## Interface
Parameters:
- RS_DEPTH, 8: number of entries (≥2).
- DATA_W, 32: operand/imm/pc width.
- TAG_W, 5: ROB tag width; tag 0 means "value present".
- OP_W, 6: opcode width.
- NUM_CDB, 2: number of broadcast channels.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  ROB exception/mispredict flush.
- disp_valid  in  1 / disp_ready  out  1: dispatch handshake; accepted when both are high.
- disp_op  in  OP_W; disp_v1, disp_v2, disp_imm, disp_pc  in  DATA_W; disp_q1, disp_q2  in  TAG_W.
- cdb_valid  in  NUM_CDB; cdb_tag  in  NUM_CDB*TAG_W; cdb_data  in  NUM_CDB*DATA_W (channel k at slice k).
- iss_valid  out  1 / iss_ready  in  1: issue handshake to ALU.
- iss_op  out  OP_W; iss_v1, iss_v2, iss_imm, iss_pc  out  DATA_W.
- occupancy  out  $clog2(RS_DEPTH+1): busy entry count, excluding the output register.

## Operation
- Entry state: busy, op, v1/q1, v2/q2, imm, pc. Age is tracked by an RS_DEPTH×RS_DEPTH age matrix (row i bit j = entry i older than j).
- Dispatch:
  - disp_ready = (occupancy < RS_DEPTH), computed from registered state. An entry freed in the same cycle is not reusable until the next cycle.
  - An accepted instruction goes to the lowest-index free entry and is marked younger than all busy entries.
- Wakeup:
  - For every busy entry operand with q≠0: if any channel has cdb_valid[k] && cdb_tag[k]==q, then v ← cdb_data[k] and q ← 0.
  - If several channels match, the lowest k wins.
  - cdb_tag==0 never matches.
- Dispatch bypass: an incoming disp_q1/disp_q2 that matches a valid CDB channel in the acceptance cycle is stored already resolved (q=0, v=cdb_data).
- Issue:
  - The output register loads when !iss_valid || iss_ready.
  - Candidates are busy entries with q1==0 && q2==0 as registered at the start of the cycle. Same-cycle wakeup does not make an entry issuable.
  - The oldest candidate is selected by the age matrix. Its payload loads into the iss_* registers, iss_valid ← 1, and its busy bit clears.
  - If the register loads and there is no candidate, iss_valid ← 0.
- Hold: while iss_valid && !iss_ready, all iss_* outputs remain stable and no entry is freed.
- Simultaneous dispatch, issue and wakeup in one cycle are all legal. occupancy changes by +1, 0 or −1 accordingly.
- flush (rst high): all busy ← 0, iss_valid ← 0, occupancy ← 0, age matrix cleared. Dispatch and CDB inputs are ignored that cycle.
- Priority: rst > flush > normal operation.

## Timing
- Reset values: iss_valid=0, all iss_* payloads=0, occupancy=0, disp_ready=1.
- Minimum dispatch-to-issue latency for a ready (or bypassed) instruction:
  - Accepted at edge E0; entry visible after E0; iss_valid high after edge E0+1.
- CDB wakeup at edge E: iss_valid with that instruction no earlier than after edge E+1.
- Back-to-back issue with iss_ready held high: one instruction per cycle.
- Full: with occupancy==RS_DEPTH, disp_ready=0 in the same cycle. Dispatch is accepted in the first cycle after the count drops.
- Flush mid-handshake: iss_valid is 0 in the cycle after the flush edge, regardless of iss_ready.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 → iss_valid=0, occupancy=0, disp_ready=1, payloads 0.
- Ready dispatch: op=3, v1=5, v2=7, q1=q2=0, pc=0x100 at E0 → iss_valid=1 after E0+1 with iss_v1=5, iss_v2=7, iss_pc=0x100; occupancy 1→0.
- Wakeup and ordering: dispatch A(q1=4), then B(ready), then C(ready). Broadcast tag 4 data 0x55 on channel 1 → issue order B, C, A with A.v1=0x55. Verify oldest-first by dispatching C before B in a second run.
- Same-cycle bypass plus dual CDB: dispatch q1=6, q2=9 while channel 0 carries tag 6 / 0x11 and channel 1 carries tag 9 / 0x22 → issued v1=0x11, v2=0x22 with minimum latency.
- Full and backpressure:
  - Fill 8 entries with iss_ready=0 → disp_ready=0 at occupancy 8; iss_* stable for 5 cycles.
  - Raise iss_ready → one issue per cycle; disp_ready returns to 1 the cycle after the first free.
- Flush: 5 busy entries, iss_valid=1, and flush asserted together with disp_valid and a matching CDB → next cycle occupancy=0, iss_valid=0; the dispatched instruction is not stored.

Source files
------------

// File: rtl/rs_multi_cdb.sv
// Reservation station for one ALU: captures operands from NUM_CDB broadcast
// channels and issues the oldest ready entry through a registered output stage.
module rs_multi_cdb #(
    parameter int RS_DEPTH = 8,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 6,
    parameter int NUM_CDB  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_W-1:0]               disp_op,
    input  logic [DATA_W-1:0]             disp_v1,
    input  logic [DATA_W-1:0]             disp_v2,
    input  logic [DATA_W-1:0]             disp_imm,
    input  logic [DATA_W-1:0]             disp_pc,
    input  logic [TAG_W-1:0]              disp_q1,
    input  logic [TAG_W-1:0]              disp_q2,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [OP_W-1:0]               iss_op,
    output logic [DATA_W-1:0]             iss_v1,
    output logic [DATA_W-1:0]             iss_v2,
    output logic [DATA_W-1:0]             iss_imm,
    output logic [DATA_W-1:0]             iss_pc,
    output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    // Returns {hit, data}; the lowest matching channel wins and tag 0 never hits.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (tag != '0) && (tags[k*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, data[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    logic [RS_DEPTH-1:0]               busy_q, busy_d;
    logic [OP_W-1:0]                   op_q  [RS_DEPTH];
    logic [OP_W-1:0]                   op_d  [RS_DEPTH];
    logic [DATA_W-1:0]                 v1_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 v1_d  [RS_DEPTH];
    logic [DATA_W-1:0]                 v2_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 v2_d  [RS_DEPTH];
    logic [DATA_W-1:0]                 imm_q [RS_DEPTH];
    logic [DATA_W-1:0]                 imm_d [RS_DEPTH];
    logic [DATA_W-1:0]                 pc_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 pc_d  [RS_DEPTH];
    logic [TAG_W-1:0]                  q1_q  [RS_DEPTH];
    logic [TAG_W-1:0]                  q1_d  [RS_DEPTH];
    logic [TAG_W-1:0]                  q2_q  [RS_DEPTH];
    logic [TAG_W-1:0]                  q2_d  [RS_DEPTH];
    // age_q[i][j] set means entry i is older than entry j.
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
    logic [OCC_W-1:0]                  occ_q, occ_d;

    logic                              iss_valid_q;
    logic [OP_W-1:0]                   iss_op_q;
    logic [DATA_W-1:0]                 iss_v1_q, iss_v2_q, iss_imm_q, iss_pc_q;

    logic [RS_DEPTH-1:0]               cand, oldest, free_oh;
    logic [IDX_W-1:0]                  sel_idx;
    logic                              any_cand, iss_load, issue_fire, disp_fire;
    logic [DATA_W:0]                   wk1 [RS_DEPTH];
    logic [DATA_W:0]                   wk2 [RS_DEPTH];
    logic [DATA_W:0]                   bp1, bp2;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // once iss_valid is high its payload stays fixed until iss_ready is seen.
    assign disp_ready = (occ_q < OCC_W'(RS_DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign free_oh    = ~busy_q & (busy_q + RS_DEPTH'(1));
    assign iss_load   = !iss_valid_q || iss_ready;
    assign any_cand   = |cand;
    assign issue_fire = iss_load && any_cand;
    assign bp1        = cdb_lookup(disp_q1, cdb_valid, cdb_tag, cdb_data);
    assign bp2        = cdb_lookup(disp_q2, cdb_valid, cdb_tag, cdb_data);

    always_comb begin
        cand    = '0;
        oldest  = '0;
        sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cand[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest[i] = cand[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if ((j != i) && cand[j] && !age_q[i][j]) oldest[i] = 1'b0;
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oldest[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            wk1[i] = cdb_lookup(q1_q[i], cdb_valid, cdb_tag, cdb_data);
            wk2[i] = cdb_lookup(q2_q[i], cdb_valid, cdb_tag, cdb_data);
        end
    end

    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        op_d   = op_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (issue_fire && oldest[i]) begin
                busy_d[i] = 1'b0;
            end else if (busy_q[i]) begin
                if (wk1[i][DATA_W]) begin
                    v1_d[i] = wk1[i][DATA_W-1:0];
                    q1_d[i] = '0;
                end
                if (wk2[i][DATA_W]) begin
                    v2_d[i] = wk2[i][DATA_W-1:0];
                    q2_d[i] = '0;
                end
            end
            // The new entry becomes the youngest: its row clears, its column sets.
            if (disp_fire && free_oh[i]) begin
                busy_d[i] = 1'b1;
                op_d[i]   = disp_op;
                imm_d[i]  = disp_imm;
                pc_d[i]   = disp_pc;
                v1_d[i]   = bp1[DATA_W] ? bp1[DATA_W-1:0] : disp_v1;
                q1_d[i]   = bp1[DATA_W] ? '0 : disp_q1;
                v2_d[i]   = bp2[DATA_W] ? bp2[DATA_W-1:0] : disp_v2;
                q2_d[i]   = bp2[DATA_W] ? '0 : disp_q2;
                age_d[i]  = '0;
            end
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (disp_fire && free_oh[j] && (i != j)) age_d[i][j] = 1'b1;
            end
        end
        occ_d = occ_q;
        case ({disp_fire, issue_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= '0;
            age_q       <= '0;
            occ_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_v1_q    <= '0;
            iss_v2_q    <= '0;
            iss_imm_q   <= '0;
            iss_pc_q    <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
            end
        end else if (flush) begin
            busy_q      <= '0;
            age_q       <= '0;
            occ_q       <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            occ_q  <= occ_d;
            op_q   <= op_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
            if (iss_load) begin
                iss_valid_q <= any_cand;
                if (any_cand) begin
                    iss_op_q  <= op_q[sel_idx];
                    iss_v1_q  <= v1_q[sel_idx];
                    iss_v2_q  <= v2_q[sel_idx];
                    iss_imm_q <= imm_q[sel_idx];
                    iss_pc_q  <= pc_q[sel_idx];
                end
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_op_q;
    assign iss_v1    = iss_v1_q;
    assign iss_v2    = iss_v2_q;
    assign iss_imm   = iss_imm_q;
    assign iss_pc    = iss_pc_q;
    assign occupancy = occ_q;

endmodule
